// File: rtl/jk_bank_sequencer_pkg.sv
// Shared op codes, FSM state encoding and small decode helpers for the JK bank sequencer.
package jk_bank_sequencer_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLR    = 3'b010;
    localparam logic [2:0] OP_TOG    = 3'b011;
    localparam logic [2:0] OP_CNT_UP = 3'b100;
    localparam logic [2:0] OP_CNT_DN = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

    function automatic logic op_is_masked(input logic [2:0] op);
        return (op == OP_SET) || (op == OP_CLR) || (op == OP_TOG);
    endfunction

    function automatic logic op_is_count(input logic [2:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN);
    endfunction

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and bank status bundle between a register-control master and the sequencer.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_len,
        input  cmd_ready, q, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_len,
        output cmd_ready, q, busy, done, err
    );
endinterface

// File: rtl/jk_bank_sequencer_cell.sv
// Single JK flip-flop of the bank: 00 hold, 01 clear, 10 set, 11 toggle; sync active-low reset.
module jk_bank_sequencer_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller for a bank of JK cells: masked set/clear/toggle and up/down counting.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | ready for a command; all j=k=0
//   ST_APPLY | one cycle driving masked set/clear/toggle onto the bank
//   ST_COUNT | one count step per cycle until the remaining length runs out
//   ST_DONE  | one-cycle done pulse (err for illegal ops); bank holds
module jk_bank_sequencer
    import jk_bank_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    jk_bank_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

    state_e           state;
    state_e           state_nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [CNT_W-1:0] len_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] toggle;
    logic             carry;
    logic             accept;

    assign accept = bus.cmd_valid & bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_r   <= OP_NOP;
            mask_r <= '0;
            len_r  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r   <= bus.cmd_op;
                mask_r <= bus.cmd_mask;
                len_r  <= bus.cmd_len;
            end else if (state == ST_COUNT) begin
                len_r <= len_r - LEN_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_is_masked(bus.cmd_op))
                        state_nxt = ST_APPLY;
                    else if (op_is_count(bus.cmd_op) && (bus.cmd_len != '0))
                        state_nxt = ST_COUNT;
                    else
                        state_nxt = ST_DONE;
                end
            end
            ST_APPLY: state_nxt = ST_DONE;
            ST_COUNT: if (len_r <= LEN_ONE) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bit i toggles when every lower bit is 1 (up) or 0 (down): ripple-carry of the count.
    always_comb begin
        toggle = '0;
        carry  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = carry;
            carry     = carry & ((op_r == OP_CNT_DN) ? ~q[i] : q[i]);
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        case (state)
            ST_APPLY: begin
                case (op_r)
                    OP_SET:  j = mask_r;
                    OP_CLR:  k = mask_r;
                    OP_TOG: begin
                        j = mask_r;
                        k = mask_r;
                    end
                    default: ;
                endcase
            end
            ST_COUNT: begin
                j = toggle;
                k = toggle;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_bank_sequencer_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q[g])
        );
    end

    assign bus.q         = q;
    assign bus.cmd_ready = (state == ST_IDLE) & reset;
    assign bus.busy      = (state == ST_APPLY) || (state == ST_COUNT);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = (state == ST_DONE) && op_is_illegal(op_r);

endmodule
